// File: rtl/spi_sclk_ctrl.sv
// SPI serial-clock sequencer: chip-select setup, nbits SCLK periods, hold, release.
// Optional SPI_SCLK_CPOL_EN adds a cpol input selecting the SCLK idle level per transfer.
module spi_sclk_ctrl #(
    parameter int unsigned DIV_W    = 8,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef SPI_SCLK_CPOL_EN
    input  logic             cpol,
`endif
    input  logic [DIV_W-1:0] half_div,
    input  logic [CNT_W-1:0] nbits,
    output logic             busy,
    output logic             done,
    output logic             cs_n,
    output logic             sclk,
    output logic             lead_stb,
    output logic             trail_stb,
    output logic [CNT_W-1:0] bit_idx
);

    localparam int unsigned PhMax = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PhW   = (PhMax < 2) ? 1 : $clog2(PhMax + 1);
    localparam logic [CNT_W-1:0] BitOne = CNT_W'(1);
    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
    localparam logic [PhW-1:0]   PhOne  = PhW'(1);

    typedef enum logic [1:0] {StIdle, StSetup, StRun, StHold} state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] hd_q, hd_d, div_q, div_d;
    logic [CNT_W-1:0] nb_q, nb_d, bit_q, bit_d;
    logic [PhW-1:0]   ph_q, ph_d;
    logic             idle_q, idle_d, last_q, last_d;
    logic             sclk_q, sclk_d, lead_q, lead_d, trail_q, trail_d;
    logic             done_q, done_d, busy_q, busy_d, cs_n_q, cs_n_d;
    logic             cpol_in;

`ifdef SPI_SCLK_CPOL_EN
    assign cpol_in = cpol;
`else
    assign cpol_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hd_d    = hd_q;
        nb_d    = nb_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ph_d    = ph_q;
        idle_d  = idle_q;
        last_d  = last_q;
        sclk_d  = sclk_q;
        lead_d  = 1'b0;
        trail_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSetup;
                    hd_d    = half_div;
                    nb_d    = nbits;
                    idle_d  = cpol_in;
                    sclk_d  = cpol_in;
                    ph_d    = '0;
                end
            end
            StSetup: begin
                if (ph_q == PhW'(CS_SETUP - 1)) begin
                    state_d = StRun;
                    div_d   = '0;
                    bit_d   = '0;
                    // Zero-length transfer spends one RUN cycle with no edges, then holds.
                    last_d  = (nb_q == '0);
                end else begin
                    ph_d = ph_q + PhOne;
                end
            end
            StRun: begin
                if (last_q) begin
                    state_d = StHold;
                    ph_d    = '0;
                    bit_d   = '0;
                end else if (div_q == hd_q) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (sclk_q == idle_q) begin
                        lead_d = 1'b1;
                    end else begin
                        trail_d = 1'b1;
                        if (bit_q + BitOne == nb_q) begin
                            last_d = 1'b1;
                        end else begin
                            bit_d = bit_q + BitOne;
                        end
                    end
                end else begin
                    div_d = div_q + DivOne;
                end
            end
            StHold: begin
                if (ph_q == PhW'(CS_HOLD - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    ph_d = ph_q + PhOne;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
            sclk_d  = idle_q;
            lead_d  = 1'b0;
            trail_d = 1'b0;
            done_d  = 1'b0;
            bit_d   = '0;
            div_d   = '0;
            last_d  = 1'b0;
        end
        busy_d = (state_d != StIdle);
        cs_n_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= StIdle;
            hd_q    <= '0;
            nb_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            ph_q    <= '0;
            idle_q  <= 1'b0;
            last_q  <= 1'b0;
            sclk_q  <= 1'b0;
            lead_q  <= 1'b0;
            trail_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            hd_q    <= hd_d;
            nb_q    <= nb_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ph_q    <= ph_d;
            idle_q  <= idle_d;
            last_q  <= last_d;
            sclk_q  <= sclk_d;
            lead_q  <= lead_d;
            trail_q <= trail_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cs_n_q  <= cs_n_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cs_n      = cs_n_q;
    assign sclk      = sclk_q;
    assign lead_stb  = lead_q;
    assign trail_stb = trail_q;
    assign bit_idx   = bit_q;

endmodule
